// File: rtl/y86_mem_pkg.sv
// Shared constants and types for the Y86 data-memory responder and its byte array.
package y86_mem_pkg;

  localparam int DMEM_BYTES_DEFAULT = 8192;
  localparam int DMEM_LAT_DEFAULT   = 2;

  localparam int WORD_BITS  = 64;
  localparam int BYTE_BITS  = 8;
  localparam int WORD_BYTES = WORD_BITS / BYTE_BITS;
  localparam int CNT_BITS   = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Byte-addressed data memory with one 8-byte little-endian read port and one write port.
module dmem_array
  import y86_mem_pkg::*;
#(
  parameter int MEM_BYTES = DMEM_BYTES_DEFAULT,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [WORD_BITS-1:0] wdata_i,
  output logic [WORD_BITS-1:0] rdata_o
);

  logic [BYTE_BITS-1:0] mem_q [MEM_BYTES];

  // Contents are deliberately not reset so data survives a responder reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        mem_q[addr_i + AW'(i)] <= wdata_i[BYTE_BITS*i +: BYTE_BITS];
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      rdata_o[BYTE_BITS*i +: BYTE_BITS] = mem_q[addr_i + AW'(i)];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accept one request, wait LATENCY cycles, hold the response.
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag addresses with addr[2:0] != 0 as errors.
module dmem_responder
  import y86_mem_pkg::*;
#(
  parameter int MEM_BYTES = DMEM_BYTES_DEFAULT,
  parameter int LATENCY   = DMEM_LAT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [WORD_BITS-1:0] req_addr,
  input  logic [WORD_BITS-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WORD_BITS-1:0] resp_rdata,
  output logic                 resp_err
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [WORD_BITS-1:0] LAST_OK  = WORD_BITS'(MEM_BYTES - WORD_BYTES);
  localparam logic [CNT_BITS-1:0]  CNT_LOAD = CNT_BITS'(LATENCY - 1);

  dmem_state_e state_q, state_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic                 write_q, write_d;
  logic [WORD_BITS-1:0] addr_q, addr_d;
  logic [WORD_BITS-1:0] wdata_q, wdata_d;
  logic [WORD_BITS-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic                 access_err;
  logic                 commit;
  logic [WORD_BITS-1:0] arr_rdata;

  always_comb begin
`ifdef DMEM_ALIGN_CHECK_EN
    access_err = (addr_q > LAST_OK) || (addr_q[2:0] != 3'b000);
`else
    access_err = (addr_q > LAST_OK);
`endif
  end

  // Reset gates the commit so an access aborted on its final WAIT cycle leaves memory untouched.
  dmem_array #(
    .MEM_BYTES(MEM_BYTES),
    .AW       (AW)
  ) u_array (
    .clk    (clk),
    .we_i   (commit && !rst),
    .addr_i (addr_q[AW-1:0]),
    .wdata_i(wdata_q),
    .rdata_o(arr_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    commit     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          err_d   = access_err;
          rdata_d = (write_q || access_err) ? '0 : arr_rdata;
          commit  = write_q && !access_err;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
